// File: rtl/ccx_ic_pkg.sv
// Shared types and helpers for the core complex N-master to M-slave crossbar.
package ccx_ic_pkg;

   localparam int CCX_AW     = 39;
   localparam int CCX_DW     = 64;
   localparam int CCX_MAX_AW = 64;

   typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

   // Addresses are zero-extended to CCX_MAX_AW so one helper serves any AW.
   function automatic logic addr_match(input logic [CCX_MAX_AW-1:0] addr,
                                       input logic [CCX_MAX_AW-1:0] base,
                                       input logic [CCX_MAX_AW-1:0] mask);
      return (addr & mask) == base;
   endfunction

endpackage

// File: rtl/ccx_ic_rr_arb.sv
// Per-slave arbiter: round-robin or fixed priority, holding its winner while the slave stalls.
module ccx_ic_rr_arb
   import ccx_ic_pkg::*;
#(
   parameter int  NM     = 2,
   parameter bit  ARB_RR = 1'b1,
   localparam int PW     = (NM > 1) ? $clog2(NM) : 1
) (
   input  logic          g_clk,
   input  logic          g_resetn,
   input  logic [NM-1:0] i_req,
   input  logic          i_s_gnt,
   output logic [NM-1:0] o_winner,
   output logic [NM-1:0] o_accept,
   output logic [PW-1:0] o_ptr,
   output logic [PW-1:0] o_lock_idx,
   output logic          o_locked
);

   arb_state_t    r_state;
   logic [PW-1:0] r_ptr;
   logic [PW-1:0] r_lock_idx;

   logic [NM-1:0] w_winner;
   logic [PW-1:0] w_win_idx;
   logic [PW-1:0] w_next_ptr;
   logic          w_found;
   int            w_j;

   // A locked slave keeps its stalled master; a vanished lock holder releases the slave.
   always_comb begin
      w_winner  = '0;
      w_win_idx = '0;
      w_found   = 1'b0;
      w_j       = 0;
      if (r_state == ARB_LOCKED) begin
         if (i_req[r_lock_idx]) begin
            w_winner[r_lock_idx] = 1'b1;
            w_win_idx            = r_lock_idx;
         end
      end else begin
         for (int i = 0; i < NM; i++) begin
            w_j = ARB_RR ? int'(r_ptr) + i : i;
            if (w_j >= NM) w_j = w_j - NM;
            if (!w_found && i_req[PW'(w_j)]) begin
               w_found             = 1'b1;
               w_winner[PW'(w_j)]  = 1'b1;
               w_win_idx           = PW'(w_j);
            end
         end
      end
   end

   assign w_next_ptr = (w_win_idx == PW'(NM-1)) ? '0 : w_win_idx + 1'b1;

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         r_state    <= ARB_IDLE;
         r_ptr      <= '0;
         r_lock_idx <= '0;
      end else if (|w_winner) begin
         if (i_s_gnt) begin
            r_state <= ARB_IDLE;
            if (ARB_RR) r_ptr <= w_next_ptr;
         end else begin
            r_state    <= ARB_LOCKED;
            r_lock_idx <= w_win_idx;
         end
      end else begin
         r_state <= ARB_IDLE;
      end
   end

   assign o_winner   = w_winner;
   assign o_accept   = w_winner & {NM{i_s_gnt}};
   assign o_ptr      = r_ptr;
   assign o_lock_idx = r_lock_idx;
   assign o_locked   = (r_state == ARB_LOCKED);

endmodule

// File: rtl/ccx_ic_xbar.sv
// Address-decoded NM x NS memory crossbar with per-slave arbitration and
// one-cycle response routing back to each master.
module ccx_ic_xbar
   import ccx_ic_pkg::*;
#(
   parameter int             AW     = CCX_AW,
   parameter int             DW     = CCX_DW,
   parameter int             NM     = 2,
   parameter int             NS     = 3,
   parameter logic [NS*AW-1:0] S_BASE = {39'h10000000, 39'h00010000, 39'h00000000},
   parameter logic [NS*AW-1:0] S_MASK = {~39'h0FFFFFFF, ~39'h0000FFFF, ~39'h000003FF},
   parameter bit             ARB_RR = 1'b1,
   localparam int            SW     = DW / 8,
   localparam int            PW     = (NM > 1) ? $clog2(NM) : 1,
   localparam int            SSW    = (NS > 1) ? $clog2(NS) : 1
) (
   input  logic             g_clk,
   input  logic             g_resetn,
   input  logic [NM-1:0]    m_req,
   input  logic [NM*AW-1:0] m_addr,
   input  logic [NM-1:0]    m_wen,
   input  logic [NM*SW-1:0] m_strb,
   input  logic [NM*DW-1:0] m_wdata,
   output logic [NM-1:0]    m_gnt,
   output logic [NM-1:0]    m_err,
   output logic [NM*DW-1:0] m_rdata,
   output logic [NS-1:0]    s_req,
   output logic [NS*AW-1:0] s_addr,
   output logic [NS-1:0]    s_wen,
   output logic [NS*SW-1:0] s_strb,
   output logic [NS*DW-1:0] s_wdata,
   input  logic [NS-1:0]    s_gnt,
   input  logic [NS-1:0]    s_err,
   input  logic [NS*DW-1:0] s_rdata
);

   logic [NM-1:0][SSW-1:0] w_sel;
   logic [NM-1:0]          w_dec_err;
   logic [NS-1:0][NM-1:0]  w_sreq;
   logic [NS-1:0][NM-1:0]  w_win;
   logic [NS-1:0][NM-1:0]  w_acc;
   logic [NS-1:0][PW-1:0]  w_arb_ptr;
   logic [NS-1:0][PW-1:0]  w_arb_lock;
   logic [NS-1:0]          w_arb_locked;

   logic [NM-1:0]          r_rsp_vld;
   logic [NM-1:0]          r_rsp_dec;
   logic [NM-1:0][SSW-1:0] r_rsp_sel;

   // Descending scan so the lowest matching slave index wins on overlap.
   always_comb begin
      w_sel     = '0;
      w_dec_err = '1;
      for (int m = 0; m < NM; m++) begin
         for (int s = NS-1; s >= 0; s--) begin
            if (addr_match(CCX_MAX_AW'(m_addr[m*AW +: AW]),
                           CCX_MAX_AW'(S_BASE[s*AW +: AW]),
                           CCX_MAX_AW'(S_MASK[s*AW +: AW]))) begin
               w_sel[m]     = SSW'(s);
               w_dec_err[m] = 1'b0;
            end
         end
      end
   end

   always_comb begin
      w_sreq = '0;
      for (int s = 0; s < NS; s++)
         for (int m = 0; m < NM; m++)
            w_sreq[s][m] = m_req[m] && !w_dec_err[m] && (w_sel[m] == SSW'(s));
   end

   for (genvar gs = 0; gs < NS; gs++) begin : g_arb
      ccx_ic_rr_arb #(
         .NM     (NM),
         .ARB_RR (ARB_RR)
      ) u_arb (
         .g_clk      (g_clk),
         .g_resetn   (g_resetn),
         .i_req      (w_sreq[gs]),
         .i_s_gnt    (s_gnt[gs]),
         .o_winner   (w_win[gs]),
         .o_accept   (w_acc[gs]),
         .o_ptr      (w_arb_ptr[gs]),
         .o_lock_idx (w_arb_lock[gs]),
         .o_locked   (w_arb_locked[gs])
      );
   end

   // Winners are one-hot, so an idle slave sees an all-zero payload.
   always_comb begin
      s_req   = '0;
      s_addr  = '0;
      s_wen   = '0;
      s_strb  = '0;
      s_wdata = '0;
      for (int s = 0; s < NS; s++) begin
         s_req[s] = |w_win[s];
         for (int m = 0; m < NM; m++) begin
            if (w_win[s][m]) begin
               s_addr[s*AW +: AW]  = m_addr[m*AW +: AW];
               s_wen[s]            = m_wen[m];
               s_strb[s*SW +: SW]  = m_strb[m*SW +: SW];
               s_wdata[s*DW +: DW] = m_wdata[m*DW +: DW];
            end
         end
      end
   end

   always_comb begin
      m_gnt = m_req & w_dec_err;
      for (int s = 0; s < NS; s++) m_gnt = m_gnt | w_acc[s];
   end

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         r_rsp_vld <= '0;
         r_rsp_dec <= '0;
         r_rsp_sel <= '0;
      end else begin
         r_rsp_vld <= m_gnt;
         for (int m = 0; m < NM; m++) begin
            if (m_gnt[m]) begin
               r_rsp_sel[m] <= w_sel[m];
               r_rsp_dec[m] <= w_dec_err[m];
            end
         end
      end
   end

   always_comb begin
      m_rdata = '0;
      m_err   = '0;
      for (int m = 0; m < NM; m++) begin
         if (r_rsp_vld[m]) begin
            if (r_rsp_dec[m]) begin
               m_err[m] = 1'b1;
            end else begin
               m_rdata[m*DW +: DW] = s_rdata[r_rsp_sel[m]*DW +: DW];
               m_err[m]            = s_err[r_rsp_sel[m]];
            end
         end
      end
   end

endmodule

// File: tb/tb_ccx_ic_xbar.sv
// Directed bench: a round-robin and a fixed-priority crossbar share all stimulus
// and are checked against hand-computed grant, request and response values.
module tb_ccx_ic_xbar;

   localparam int AW = 39;
   localparam int DW = 64;
   localparam logic [AW-1:0] ROM  = 39'h00000008;
   localparam logic [AW-1:0] RAM  = 39'h00010008;
   localparam logic [AW-1:0] RAM2 = 39'h00010010;
   localparam logic [AW-1:0] EXT0 = 39'h10000080;
   localparam logic [AW-1:0] EXT1 = 39'h10000040;
   localparam logic [AW-1:0] UNM  = 39'h00020000;
   localparam logic [63:0]   W0   = 64'hCAFE_F00D_0000_0000;
   localparam logic [63:0]   W1   = 64'hDEAD_BEEF_0000_0001;

   logic          g_clk = 1'b0;
   logic          g_resetn = 1'b1;
   logic [1:0]    m_req;
   logic [77:0]   m_addr;
   logic [1:0]    m_wen;
   logic [15:0]   m_strb;
   logic [127:0]  m_wdata;
   logic [2:0]    s_gnt;
   logic [2:0]    s_err;
   logic [191:0]  s_rdata;

   logic [1:0]    rrGnt, rrErr, fpGnt, fpErr;
   logic [127:0]  rrRdata, fpRdata;
   logic [2:0]    rrSReq, rrSWen, fpSReq, fpSWen;
   logic [116:0]  rrSAddr, fpSAddr;
   logic [23:0]   rrSStrb, fpSStrb;
   logic [191:0]  rrSWdata, fpSWdata;

   int nPass = 0;
   int nChecks = 0;

   always #5 g_clk = ~g_clk;

   ccx_ic_xbar #(.ARB_RR(1'b1)) dut_rr (
      .g_clk(g_clk), .g_resetn(g_resetn),
      .m_req(m_req), .m_addr(m_addr), .m_wen(m_wen), .m_strb(m_strb), .m_wdata(m_wdata),
      .m_gnt(rrGnt), .m_err(rrErr), .m_rdata(rrRdata),
      .s_req(rrSReq), .s_addr(rrSAddr), .s_wen(rrSWen), .s_strb(rrSStrb), .s_wdata(rrSWdata),
      .s_gnt(s_gnt), .s_err(s_err), .s_rdata(s_rdata)
   );

   ccx_ic_xbar #(.ARB_RR(1'b0)) dut_fp (
      .g_clk(g_clk), .g_resetn(g_resetn),
      .m_req(m_req), .m_addr(m_addr), .m_wen(m_wen), .m_strb(m_strb), .m_wdata(m_wdata),
      .m_gnt(fpGnt), .m_err(fpErr), .m_rdata(fpRdata),
      .s_req(fpSReq), .s_addr(fpSAddr), .s_wen(fpSWen), .s_strb(fpSStrb), .s_wdata(fpSWdata),
      .s_gnt(s_gnt), .s_err(s_err), .s_rdata(s_rdata)
   );

   // src fields: two bits per master, 0 = no response data, else slave index + 1
   typedef struct {
      logic [1:0]    req;
      logic [AW-1:0] addr0;
      logic [AW-1:0] addr1;
      logic [1:0]    wen;
      logic [2:0]    sgnt;
      logic [2:0]    serr;
      logic [1:0]    gntRr;
      logic [1:0]    gntFp;
      logic [2:0]    sreq;
      logic [1:0]    errExp;
      logic [3:0]    srcRr;
      logic [3:0]    srcFp;
   } vec_t;

   vec_t vecs[12];

   function automatic logic [63:0] sdata(int s, int k);
      return {8'h5A, 8'(s), 16'h0, 32'(k)};
   endfunction

   function automatic logic [127:0] expRdata(logic [3:0] src, int k);
      logic [127:0] r;
      logic [1:0]   f;
      r = '0;
      for (int m = 0; m < 2; m++) begin
         f = src[2*m +: 2];
         if (f != 2'd0) r[64*m +: 64] = sdata(int'(f) - 1, k);
      end
      return r;
   endfunction

   task automatic driveSlaves(input logic [2:0] g, input logic [2:0] e, input int k);
      s_gnt   = g;
      s_err   = e;
      s_rdata = {sdata(2, k), sdata(1, k), sdata(0, k)};
   endtask

   task automatic applyStimulus(input vec_t v, input int k);
      m_req   = v.req;
      m_addr  = {v.addr1, v.addr0};
      m_wen   = v.wen;
      m_strb  = 16'hFFFF;
      m_wdata = {64'h1111_0000_0000_0000 + 64'(k), 64'h2222_0000_0000_0000 + 64'(k)};
      driveSlaves(v.sgnt, v.serr, k);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] exp);
      nChecks++;
      if (act !== exp) $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      else nPass++;
   endtask

   task automatic nextCycle();
      @(posedge g_clk);
      #1;
   endtask

   initial begin
      vecs[0]  = '{2'b11, RAM,  RAM,  2'b00, 3'b111, 3'b000, 2'b01, 2'b01, 3'b010, 2'b00, 4'b0000, 4'b0000};
      vecs[1]  = '{2'b11, RAM,  RAM,  2'b00, 3'b111, 3'b000, 2'b10, 2'b01, 3'b010, 2'b00, 4'b0010, 4'b0010};
      vecs[2]  = '{2'b11, RAM,  RAM,  2'b00, 3'b111, 3'b000, 2'b01, 2'b01, 3'b010, 2'b00, 4'b1000, 4'b0010};
      vecs[3]  = '{2'b11, RAM,  RAM,  2'b00, 3'b111, 3'b000, 2'b10, 2'b01, 3'b010, 2'b00, 4'b0010, 4'b0010};
      vecs[4]  = '{2'b00, '0,   '0,   2'b00, 3'b111, 3'b000, 2'b00, 2'b00, 3'b000, 2'b00, 4'b1000, 4'b0010};
      vecs[5]  = '{2'b01, UNM,  '0,   2'b00, 3'b111, 3'b000, 2'b01, 2'b01, 3'b000, 2'b00, 4'b0000, 4'b0000};
      vecs[6]  = '{2'b00, '0,   '0,   2'b00, 3'b111, 3'b111, 2'b00, 2'b00, 3'b000, 2'b01, 4'b0000, 4'b0000};
      vecs[7]  = '{2'b11, ROM,  RAM2, 2'b10, 3'b111, 3'b000, 2'b11, 2'b11, 3'b011, 2'b00, 4'b0000, 4'b0000};
      vecs[8]  = '{2'b00, '0,   '0,   2'b00, 3'b111, 3'b010, 2'b00, 2'b00, 3'b000, 2'b10, 4'b1001, 4'b1001};
      vecs[9]  = '{2'b01, UNM,  '0,   2'b00, 3'b111, 3'b000, 2'b01, 2'b01, 3'b000, 2'b00, 4'b0000, 4'b0000};
      vecs[10] = '{2'b01, RAM,  '0,   2'b00, 3'b111, 3'b000, 2'b01, 2'b01, 3'b010, 2'b01, 4'b0000, 4'b0000};
      vecs[11] = '{2'b00, '0,   '0,   2'b00, 3'b111, 3'b101, 2'b00, 2'b00, 3'b000, 2'b00, 4'b0010, 4'b0010};

      m_req = '0; m_addr = '0; m_wen = '0; m_strb = '0; m_wdata = '0;
      driveSlaves(3'b000, 3'b000, 0);
      #1 g_resetn = 1'b0;
      #11;
      checkOutput("reset rr gnt",   rrGnt,   '0);
      checkOutput("reset fp gnt",   fpGnt,   '0);
      checkOutput("reset rr err",   rrErr,   '0);
      checkOutput("reset rr rdata", rrRdata, '0);
      checkOutput("reset rr s_req", rrSReq,  '0);
      checkOutput("reset rr s_addr", rrSAddr, '0);
      checkOutput("reset rr s_wdata", rrSWdata, '0);
      checkOutput("reset fp s_req", fpSReq,  '0);
      @(negedge g_clk) g_resetn = 1'b1;
      nextCycle();

      for (int k = 0; k < 12; k++) begin
         applyStimulus(vecs[k], k);
         checkOutput($sformatf("v%0d rr gnt", k),   rrGnt,   vecs[k].gntRr);
         checkOutput($sformatf("v%0d fp gnt", k),   fpGnt,   vecs[k].gntFp);
         checkOutput($sformatf("v%0d rr s_req", k), rrSReq,  vecs[k].sreq);
         checkOutput($sformatf("v%0d fp s_req", k), fpSReq,  vecs[k].sreq);
         checkOutput($sformatf("v%0d rr err", k),   rrErr,   vecs[k].errExp);
         checkOutput($sformatf("v%0d fp err", k),   fpErr,   vecs[k].errExp);
         checkOutput($sformatf("v%0d rr rdata", k), rrRdata, expRdata(vecs[k].srcRr, k));
         checkOutput($sformatf("v%0d fp rdata", k), fpRdata, expRdata(vecs[k].srcFp, k));
         nextCycle();
      end

      // Stalled EXT slave: M1 holds the lock while M0 piles in behind it.
      m_req = 2'b10; m_addr = {EXT1, 39'h0}; m_wen = 2'b10;
      m_strb = {8'h0F, 8'h00}; m_wdata = {W1, 64'h0};
      driveSlaves(3'b011, 3'b000, 20);
      #1;
      checkOutput("lock c0 rr gnt",    rrGnt, 2'b00);
      checkOutput("lock c0 fp gnt",    fpGnt, 2'b00);
      checkOutput("lock c0 s_req",     rrSReq, 3'b100);
      checkOutput("lock c0 s_addr",    rrSAddr[2*AW +: AW], EXT1);
      checkOutput("lock c0 s_wen",     rrSWen[2], 1'b1);
      checkOutput("lock c0 s_strb",    rrSStrb[16 +: 8], 8'h0F);
      checkOutput("lock c0 fp s_strb", fpSStrb[16 +: 8], 8'h0F);
      checkOutput("lock c0 s_wdata",   rrSWdata[2*DW +: DW], W1);
      for (int c = 1; c < 3; c++) begin
         nextCycle();
         m_req = 2'b11; m_addr = {EXT1, EXT0}; m_wdata = {W1, W0};
         driveSlaves(3'b011, 3'b000, 20 + c);
         #1;
         checkOutput($sformatf("lock c%0d rr gnt", c), rrGnt, 2'b00);
         checkOutput($sformatf("lock c%0d fp gnt", c), fpGnt, 2'b00);
         checkOutput($sformatf("lock c%0d rr s_addr", c), rrSAddr[2*AW +: AW], EXT1);
         checkOutput($sformatf("lock c%0d fp s_addr", c), fpSAddr[2*AW +: AW], EXT1);
         checkOutput($sformatf("lock c%0d fp s_wdata", c), fpSWdata[2*DW +: DW], W1);
      end
      nextCycle();
      driveSlaves(3'b111, 3'b000, 23);
      #1;
      checkOutput("lock c3 rr gnt",    rrGnt, 2'b10);
      checkOutput("lock c3 fp gnt",    fpGnt, 2'b10);
      checkOutput("lock c3 s_addr",    rrSAddr[2*AW +: AW], EXT1);
      nextCycle();
      m_req = 2'b01;
      driveSlaves(3'b111, 3'b000, 24);
      #1;
      checkOutput("lock c4 rr gnt",    rrGnt, 2'b01);
      checkOutput("lock c4 fp gnt",    fpGnt, 2'b01);
      checkOutput("lock c4 s_addr",    rrSAddr[2*AW +: AW], EXT0);
      checkOutput("lock c4 s_wen",     rrSWen[2], 1'b0);
      checkOutput("lock c4 rr rdata",  rrRdata, {sdata(2, 24), 64'h0});
      checkOutput("lock c4 fp rdata",  fpRdata, {sdata(2, 24), 64'h0});
      nextCycle();
      m_req = 2'b00;
      driveSlaves(3'b111, 3'b000, 25);
      #1;
      checkOutput("lock c5 rr rdata",  rrRdata, {64'h0, sdata(2, 25)});
      checkOutput("lock c5 fp rdata",  fpRdata, {64'h0, sdata(2, 25)});
      nextCycle();

      // Reset right after an accept: response dropped, lock and pointer cleared.
      m_req = 2'b11; m_addr = {EXT1, ROM}; m_wen = 2'b10;
      driveSlaves(3'b011, 3'b000, 30);
      #1;
      checkOutput("rst r0 rr gnt", rrGnt, 2'b01);
      checkOutput("rst r0 fp gnt", fpGnt, 2'b01);
      nextCycle();
      m_req = 2'b00;
      driveSlaves(3'b111, 3'b111, 31);
      g_resetn = 1'b0;
      #1;
      checkOutput("rst r1 rr rdata", rrRdata, '0);
      checkOutput("rst r1 rr err",   rrErr,   '0);
      checkOutput("rst r1 fp rdata", fpRdata, '0);
      checkOutput("rst r1 fp err",   fpErr,   '0);
      #3 g_resetn = 1'b1;
      nextCycle();
      m_req = 2'b11; m_addr = {ROM, ROM}; m_wen = 2'b00;
      driveSlaves(3'b111, 3'b111, 32);
      #1;
      checkOutput("rst r2 rr gnt",   rrGnt,   2'b01);
      checkOutput("rst r2 fp gnt",   fpGnt,   2'b01);
      checkOutput("rst r2 rr rdata", rrRdata, '0);
      checkOutput("rst r2 rr err",   rrErr,   '0);
      nextCycle();
      m_req = 2'b01; m_addr = {39'h0, EXT0};
      driveSlaves(3'b111, 3'b000, 33);
      #1;
      checkOutput("rst r3 rr gnt",   rrGnt,   2'b01);
      checkOutput("rst r3 fp gnt",   fpGnt,   2'b01);
      checkOutput("rst r3 rr rdata", rrRdata, {64'h0, sdata(0, 33)});
      nextCycle();
      m_req = 2'b00;
      driveSlaves(3'b111, 3'b000, 34);
      #1;
      checkOutput("rst r4 rr rdata", rrRdata, {64'h0, sdata(2, 34)});
      checkOutput("rst r4 fp rdata", fpRdata, {64'h0, sdata(2, 34)});

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
